// File: rtl/tone_pkg.sv
// Shared widths, constants and helpers for the tone PWM generator.
// TONE_PWM_SILENCE_EN (defined at build time) turns high request frequencies into silence.
package tone_pkg;

  localparam int          DUTY_W         = 10;
  localparam int          FREQ_W         = 32;
  localparam int          DUTY_FULL      = 1024;
  localparam int          DUTY_SHIFT     = $clog2(DUTY_FULL);
  localparam int unsigned CLK_HZ_DEFAULT = 100_000_000;
  localparam int unsigned MIN_PERIOD     = 2;

  typedef enum logic {
    ST_SILENT = 1'b0,
    ST_ACTIVE = 1'b1
  } tone_state_e;

  // High time in clocks for a period and a duty fraction of DUTY_FULL, floored.
  function automatic logic [FREQ_W-1:0] calc_high(
    input logic [FREQ_W-1:0] period,
    input logic [DUTY_W-1:0] duty
  );
    logic [FREQ_W+DUTY_W-1:0] prod;
    prod = {{DUTY_W{1'b0}}, period} * {{FREQ_W{1'b0}}, duty};
    return prod[FREQ_W+DUTY_SHIFT-1:DUTY_SHIFT];
  endfunction

endpackage

// File: rtl/tone_period_div.sv
// Restoring divider, one quotient bit per clock; a new start restarts it and abort
// cancels it, and in both cases the interrupted division never raises done.
module tone_period_div
  import tone_pkg::*;
#(
  parameter int W = FREQ_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic         done,
  output logic         busy
);

  localparam int STEP_W = $clog2(W);

  logic [W-1:0]      rem_q;
  logic [W-1:0]      quo_q;
  logic [W-1:0]      dvs_q;
  logic [W-1:0]      res_q;
  logic [STEP_W-1:0] step_q;
  logic              busy_q;
  logic              done_q;

  logic [W:0]   rem_shift;
  logic [W:0]   rem_sub;
  logic         take;
  logic [W-1:0] rem_d;
  logic [W-1:0] quo_d;

  // The borrow out of the trial subtraction decides the quotient bit.
  always_comb begin
    rem_shift = {rem_q, quo_q[W-1]};
    rem_sub   = rem_shift - {1'b0, dvs_q};
    take      = ~rem_sub[W];
    rem_d     = take ? rem_sub[W-1:0] : rem_shift[W-1:0];
    quo_d     = {quo_q[W-2:0], take};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      res_q  <= '0;
      step_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        rem_q  <= '0;
        quo_q  <= dividend;
        dvs_q  <= divisor;
        step_q <= '0;
        busy_q <= 1'b1;
      end else if (abort) begin
        busy_q <= 1'b0;
      end else if (busy_q) begin
        rem_q  <= rem_d;
        quo_q  <= quo_d;
        step_q <= step_q + STEP_W'(1);
        if (step_q == STEP_W'(W-1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          res_q  <= quo_d;
        end
      end
    end
  end

  assign quotient = res_q;
  assign done     = done_q;
  assign busy     = busy_q;

endmodule

// File: rtl/tone_pwm_gen.sv
// Square-wave tone generator: divides CLK_HZ by the requested frequency and plays a PWM
// period with a sampled duty. TONE_PWM_SILENCE_EN makes freq >= SILENCE_HZ act as silence.
module tone_pwm_gen
  import tone_pkg::*;
#(
  parameter int unsigned CLK_HZ     = CLK_HZ_DEFAULT,
  parameter int unsigned SILENCE_HZ = 10000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FREQ_W-1:0] freq,
  input  logic [DUTY_W-1:0] duty,
  output logic              pwm,
  output logic              period_tick,
  output logic              busy
);

`ifdef TONE_PWM_SILENCE_EN
  localparam bit SILENCE_EN = 1'b1;
`else
  localparam bit SILENCE_EN = 1'b0;
`endif

  localparam logic [FREQ_W-1:0] DIVIDEND = FREQ_W'(CLK_HZ);
  localparam logic [FREQ_W-1:0] PER_MIN  = FREQ_W'(MIN_PERIOD);

  tone_state_e       state_q, state_d;
  logic [FREQ_W-1:0] req_q, req_d;
  logic [FREQ_W-1:0] cnt_q, cnt_d;
  logic [FREQ_W-1:0] period_q, period_d;
  logic [FREQ_W-1:0] high_q, high_d;
  logic [FREQ_W-1:0] pend_q, pend_d;
  logic              pend_vld_q, pend_vld_d;
  logic              pwm_q, pwm_d;
  logic              tick_q, tick_d;

  logic              mismatch;
  logic              freq_silent;
  logic              div_start;
  logic              div_abort;
  logic [FREQ_W-1:0] div_quo;
  logic              div_done;
  logic              div_busy;

  // req_q resets to zero, so any nonzero request right after reset is a mismatch.
  assign mismatch    = (freq != req_q);
  assign freq_silent = (freq == '0) || (SILENCE_EN && (freq >= FREQ_W'(SILENCE_HZ)));
  assign div_start   = mismatch && !freq_silent;
  assign div_abort   = mismatch && freq_silent;

  tone_period_div #(
    .W(FREQ_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .abort    (div_abort),
    .dividend (DIVIDEND),
    .divisor  (freq),
    .quotient (div_quo),
    .done     (div_done),
    .busy     (div_busy)
  );

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    cnt_d      = cnt_q;
    period_d   = period_q;
    high_d     = high_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;

    case (state_q)
      ST_SILENT: begin
        if (pend_vld_q) begin
          state_d    = ST_ACTIVE;
          period_d   = pend_q;
          high_d     = calc_high(pend_q, duty);
          cnt_d      = '0;
          pend_vld_d = 1'b0;
        end
      end
      ST_ACTIVE: begin
        // Duty and any new period are only taken at the wrap.
        if (cnt_q == period_q - FREQ_W'(1)) begin
          cnt_d = '0;
          if (pend_vld_q) begin
            period_d   = pend_q;
            high_d     = calc_high(pend_q, duty);
            pend_vld_d = 1'b0;
          end else begin
            high_d = calc_high(period_q, duty);
          end
        end else begin
          cnt_d = cnt_q + FREQ_W'(1);
        end
      end
      default: state_d = ST_SILENT;
    endcase

    if (div_done) begin
      pend_d     = (div_quo < PER_MIN) ? PER_MIN : div_quo;
      pend_vld_d = 1'b1;
    end

    // A new request discards any result belonging to the old one.
    if (mismatch) begin
      req_d      = freq;
      pend_vld_d = 1'b0;
      if (freq_silent) begin
        state_d  = ST_SILENT;
        cnt_d    = '0;
        period_d = '0;
        high_d   = '0;
      end
    end

    pwm_d  = (state_d == ST_ACTIVE) && (cnt_d < high_d);
    tick_d = (state_d == ST_ACTIVE) && (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_SILENT;
      req_q      <= '0;
      cnt_q      <= '0;
      period_q   <= '0;
      high_q     <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      pwm_q      <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      high_q     <= high_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      pwm_q      <= pwm_d;
      tick_q     <= tick_d;
    end
  end

  assign pwm         = pwm_q;
  assign period_tick = tick_q;
  assign busy        = div_busy;

endmodule

// File: tb/tb_tone_pwm_gen.sv
// Directed bench for tone_pwm_gen: expected periods/high times are queued when a request
// is driven and popped when the generator plays them.
module tb_tone_pwm_gen;
  import tone_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [FREQ_W-1:0] freq;
  logic [DUTY_W-1:0] duty;
  logic              pwm;
  logic              period_tick;
  logic              busy;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string       tag;
    int unsigned per;
    int unsigned hi;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  tone_pwm_gen dut (
    .clk         (clk),
    .rst         (rst),
    .freq        (freq),
    .duty        (duty),
    .pwm         (pwm),
    .period_tick (period_tick),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
    if (obs === exp_v) $display("ok   %s: %0d", tag, obs);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string tag, input int unsigned per, input int unsigned hi);
    exp_t e;
    e.tag = tag;
    e.per = per;
    e.hi  = hi;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [63:0] per, input logic [63:0] hi);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 64'(sb.size()), 1);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_period"}, per, 64'(e.per));
      check({e.tag, "_high"}, hi, 64'(e.hi));
    end
  endtask

  task automatic wait_tick(input string tag, input int limit);
    int n = 0;
    while (!period_tick && n < limit) begin
      step();
      n++;
    end
    check({tag, "_tick_seen"}, 64'(period_tick), 1);
  endtask

  // Called on a tick cycle; returns the length of this period and its pwm-high count.
  task automatic measure(input string tag, output int unsigned per, output int unsigned hi);
    int unsigned n = 0;
    int unsigned h = 0;
    do begin
      h += (pwm === 1'b1) ? 1 : 0;
      n++;
      step();
    end while (!period_tick && n < 20010);
    if (!period_tick) check({tag, "_period_end"}, 64'(period_tick), 1);
    per = n;
    hi  = h;
  endtask

  task automatic wait_busy_rise(input string tag);
    int n = 0;
    while (!busy && n < 5) begin
      step();
      n++;
    end
    check({tag, "_busy_rise"}, 64'(busy), 1);
  endtask

  task automatic count_busy(output int cnt);
    int n = 0;
    while (busy && n < 200) begin
      n++;
      step();
    end
    cnt = n;
  endtask

  task automatic quiet_run(input int cycles, output int ticks, output int highs, output int busys);
    ticks = 0;
    highs = 0;
    busys = 0;
    for (int i = 0; i < cycles; i++) begin
      ticks += period_tick ? 1 : 0;
      highs += pwm ? 1 : 0;
      busys += busy ? 1 : 0;
      step();
    end
  endtask

  initial begin
    int unsigned per, hi;
    int          nb, tk, hs, bs, loops;

    // Reset
    rst  = 1'b1;
    freq = '0;
    duty = 10'd512;
    repeat (3) step();
    rst = 1'b0;
    check("rst_pwm", 64'(pwm), 0);
    check("rst_tick", 64'(period_tick), 0);
    check("rst_busy", 64'(busy), 0);

    // 262 Hz from silence: 32 busy cycles, then the period loads
    freq = 32'd262;
    push_exp("f262", 381679, 190839);
    wait_busy_rise("f262");
    count_busy(nb);
    check("f262_busy_cycles", 64'(nb), 32);
    wait_tick("f262", 10);
    pop_check(64'(dut.period_q), 64'(dut.high_q));
    check("f262_pwm_first", 64'(pwm), 1);

    // 440 Hz while playing: result waits as pending, current period untouched
    freq = 32'd440;
    wait_busy_rise("f440");
    count_busy(nb);
    check("f440_busy_cycles", 64'(nb), 32);
    repeat (2) step();
    check("f440_cur_period", 64'(dut.period_q), 381679);
    check("f440_pend", 64'(dut.pend_q), 227272);
    check("f440_pend_vld", 64'(dut.pend_vld_q), 1);

    // Silence
    freq = '0;
    repeat (2) step();
    check("sil_pwm", 64'(pwm), 0);
    quiet_run(40, tk, hs, bs);
    check("sil_ticks", 64'(tk), 0);
    check("sil_highs", 64'(hs), 0);

    // 5 MHz: period 20, high 10
    freq = 32'd5_000_000;
    push_exp("f5M", 20, 10);
    wait_tick("f5M", 60);
    measure("f5M", per, hi);
    pop_check(64'(per), 64'(hi));

    // Switch to 4 MHz on a tick: the running period finishes as 20
    freq = 32'd4_000_000;
    push_exp("f4M_cur", 20, 10);
    push_exp("f4M_next", 25, 12);
    measure("f4M_cur", per, hi);
    pop_check(64'(per), 64'(hi));
    loops = 0;
    do begin
      measure("f4M_next", per, hi);
      loops++;
    end while (per == 20 && loops < 6);
    pop_check(64'(per), 64'(hi));

    // Duty sampled at the wrap only
    duty = 10'd0;
    push_exp("duty0_cur", 25, 12);
    push_exp("duty0_next", 25, 0);
    measure("duty0_cur", per, hi);
    pop_check(64'(per), 64'(hi));
    measure("duty0_next", per, hi);
    pop_check(64'(per), 64'(hi));
    duty = 10'd1023;
    push_exp("duty1023_cur", 25, 0);
    push_exp("duty1023_next", 25, 24);
    measure("duty1023_cur", per, hi);
    pop_check(64'(per), 64'(hi));
    measure("duty1023_next", per, hi);
    pop_check(64'(per), 64'(hi));
    duty = 10'd512;

    // Request change at division step 10: restart, busy stays high
    freq = '0;
    repeat (2) step();
    freq = 32'd5_000_000;
    wait_busy_rise("restart");
    repeat (10) step();
    freq = 32'd4_000_000;
    push_exp("restart", 25, 12);
    step();
    count_busy(nb);
    check("restart_busy_cycles", 64'(nb), 32);
    wait_tick("restart", 10);
    measure("restart", per, hi);
    pop_check(64'(per), 64'(hi));

    // 10 kHz: silence threshold when enabled
    freq = 32'd10000;
`ifdef TONE_PWM_SILENCE_EN
    repeat (2) step();
    quiet_run(300, tk, hs, bs);
    check("f10k_sil_ticks", 64'(tk), 0);
    check("f10k_sil_highs", 64'(hs), 0);
    check("f10k_sil_busy", 64'(bs), 0);
`else
    push_exp("f10k", 10000, 5000);
    wait_tick("f10k", 40);
    loops = 0;
    do begin
      measure("f10k", per, hi);
      loops++;
    end while (per == 25 && loops < 8);
    pop_check(64'(per), 64'(hi));
`endif

    // 262 Hz loaded with duty 1023, then with duty 0
    freq = '0;
    repeat (2) step();
    duty = 10'd1023;
    freq = 32'd262;
    push_exp("f262_d1023", 381679, 381306);
    wait_tick("f262_d1023", 60);
    pop_check(64'(dut.period_q), 64'(dut.high_q));
    freq = '0;
    repeat (2) step();
    duty = 10'd0;
    freq = 32'd262;
    push_exp("f262_d0", 381679, 0);
    wait_tick("f262_d0", 60);
    pop_check(64'(dut.period_q), 64'(dut.high_q));
    check("f262_d0_pwm", 64'(pwm), 0);

    // Reset in the middle of a division
    freq = '0;
    repeat (3) step();
    duty = 10'd512;
    freq = 32'd262;
    wait_busy_rise("rstdiv");
    repeat (5) step();
    rst  = 1'b1;
    freq = '0;
    step();
    check("rstdiv_busy", 64'(busy), 0);
    check("rstdiv_pwm", 64'(pwm), 0);
    rst = 1'b0;
    quiet_run(60, tk, hs, bs);
    check("rstdiv_ticks", 64'(tk), 0);
    check("rstdiv_busy_after", 64'(bs), 0);
    check("rstdiv_period", 64'(dut.period_q), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
